// File: rtl/register_pipe_pkg.sv
// rtl/register_pipe_pkg.sv - shared constants, types and helpers for the elastic register pipe
package register_pipe_pkg;

    localparam int DEPTH_MAX = 16;

    typedef logic [7:0] data8_t;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int level_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/register_slice.sv
// rtl/register_slice.sv - one elastic stage: valid bit, data register, local ready equation
module register_slice
    import register_pipe_pkg::*;
#(
    parameter int               WIDTH   = $bits(data8_t),
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             flush,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    input  logic             i_dn_ready,
    output logic             o_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_v;
    logic [WIDTH-1:0] r_d;

    // An empty stage always accepts, which is what lets bubbles collapse under stall.
    assign o_ready = !r_v || i_dn_ready;
    assign o_valid = r_v;
    assign o_data  = r_d;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_v <= 1'b0;
            r_d <= RST_VAL;
        end else if (flush) begin
            r_v <= 1'b0;
            r_d <= RST_VAL;
        end else if (o_ready) begin
            r_v <= i_up_valid;
            if (i_up_valid) begin
                r_d <= i_up_data;
            end
        end
    end

endmodule

// File: rtl/register_pipe.sv
// rtl/register_pipe.sv - DEPTH-stage elastic register pipeline; REGISTER_PIPE_LEVEL_EN adds level/full outputs
module register_pipe
    import register_pipe_pkg::*;
#(
    parameter int               WIDTH   = $bits(data8_t),
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst_,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
`ifdef REGISTER_PIPE_LEVEL_EN
    output logic [level_width(DEPTH)-1:0]  level,
    output logic                           full,
`endif
    output logic [WIDTH-1:0]               out_data
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;
        logic             w_dn_ready;
        logic             w_valid;
        logic             w_ready;
        logic [WIDTH-1:0] w_data;

        if (i == 0) begin : g_head
            assign w_up_valid = in_valid;
            assign w_up_data  = in_data;
        end else begin : g_body
            assign w_up_valid = g_stage[i-1].w_valid;
            assign w_up_data  = g_stage[i-1].w_data;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign w_dn_ready = out_ready;
        end else begin : g_mid
            assign w_dn_ready = g_stage[i+1].w_ready;
        end

        register_slice #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_slice (
            .clk        (clk),
            .rst_       (rst_),
            .flush      (flush),
            .i_up_valid (w_up_valid),
            .i_up_data  (w_up_data),
            .i_dn_ready (w_dn_ready),
            .o_valid    (w_valid),
            .o_ready    (w_ready),
            .o_data     (w_data)
        );
    end

    assign in_ready  = g_stage[0].w_ready;
    assign out_valid = g_stage[DEPTH-1].w_valid;
    assign out_data  = g_stage[DEPTH-1].w_data;

`ifdef REGISTER_PIPE_LEVEL_EN
    localparam int LW = level_width(DEPTH);

    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] r_level;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Occupancy only moves at the two ends, so tracking push/pop equals the popcount of stage valids.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_level <= '0;
        end else if (flush) begin
            r_level <= '0;
        end else begin
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    assign level = r_level;
    assign full  = (r_level == LW'(DEPTH));
`endif

endmodule

// File: doc/register_pipe.md
Name: register_pipe

Overview:
- Parametrised elastic register pipeline: DEPTH back-to-back register stages, each WIDTH bits wide, with a valid/ready handshake on both sides.
- Successor to the fixed 8-bit enable register. Adds configurable width and depth, back-pressure, a synchronous flush, and per-stage bubble collapsing.
- Sits on datapaths between producer/consumer blocks that need timing isolation without losing throughput.

Parameters:
- WIDTH, 8, data bits per stage.
- DEPTH, 2, number of register stages; legal range 1..16.
- RST_VAL, '0, value loaded into every stage data register on reset and on flush.

Ports:
- clk  input  1  rising-edge clock
- rst_  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of all stage valids
- in_valid  input  1  upstream data valid
- in_ready  output  1  pipe can accept in_data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  last stage holds valid data
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  last-stage data

Behaviour:
- Per-stage state: v[i] and d[i] for i = 0..DEPTH-1. Stage 0 is fed by the input; stage DEPTH-1 drives the outputs.
- Reset (rst_ low, asynchronous): all v[i] = 0, all d[i] = RST_VAL.
  - Outputs during reset: out_valid = 0, out_data = RST_VAL, in_ready = 1.
  - Reset asserted mid-transfer discards all contents; no partial data survives.
- Stage ready: rdy[DEPTH-1] = !v[DEPTH-1] || out_ready; rdy[i] = !v[i] || rdy[i+1]. in_ready = rdy[0].
- Ready is combinational back through the stages, so bubbles collapse: an empty stage accepts even while downstream is stalled.
- On a rising edge with rdy[i] = 1:
  - v[i] <= upstream valid (in_valid for i = 0, else v[i-1]).
  - d[i] loads upstream data only when the upstream valid is 1; otherwise d[i] holds.
- On a rising edge with rdy[i] = 0: v[i] and d[i] hold.
- Latency: with out_ready held at 1, a word accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1. DEPTH = 1 gives one register.
- Throughput: one word per cycle while out_ready = 1.
- Hold rule: once out_valid = 1, out_valid and out_data stay stable until the cycle in which out_ready = 1.
- Full: all v = 1 and out_ready = 0, so in_ready = 0 and input is stalled. Capacity is exactly DEPTH words.
- Empty: all v = 0, so out_valid = 0 and in_ready = 1 regardless of out_ready.
- Simultaneous push and pop on a full pipe: in_ready = 1 because out_ready = 1. The word advances with no loss and no duplication.
- Flush (synchronous, takes priority over the handshake):
  - At the edge, all v <= 0, all d <= RST_VAL.
  - in_data presented in the flush cycle is dropped, even though in_ready may read 1.
  - out_valid falls one edge after flush; the flush-cycle output is still consumed if out_ready = 1.
- No combinational path from in_valid or in_data to out_*.

Optional Feature:
- Macro: REGISTER_PIPE_LEVEL_EN.
- When defined:
  - Adds output port level, width $clog2(DEPTH+1), equal to the count of set v[i] (registered population count).
  - Adds output port full, asserted when level == DEPTH.
  - Both read 0 during reset and after flush.
- When undefined: the ports and counter logic are absent; the remaining behaviour is identical.

Decomposition:
- Package register_pipe_pkg holds:
  - DEPTH_MAX = 16.
  - A level-width helper function.
  - Typedef for the default 8-bit data word.
- Sub-module register_slice: one stage (v, d, local ready equation).
  - register_pipe instantiates DEPTH slices in a generate loop and wires the ready chain.

Test Plan:
- Reset check (WIDTH=8, DEPTH=3): assert rst_ low mid-stream with 3 words loaded -> out_valid=0, out_data=8'h00, in_ready=1 immediately, before the next edge.
- Streaming: out_ready=1, push 8'h11, 8'h22, 8'h33, 8'h44 on consecutive edges -> out_data shows 11,22,33,44 on consecutive cycles; the first appears 2 edges after acceptance.
- Back-pressure: out_ready=0, push 8'hA1..8'hA4 -> A1..A3 accepted, in_ready=0 when A4 is offered; raising out_ready drains A1,A2,A3,A4 in order with no loss.
- Bubble collapse: load one word 8'h5A, hold out_ready=0 -> in_ready stays 1 until 3 words are resident; a later push fills stages 0..1.
- Flush with in_valid=1 and data 8'hFF on a full pipe -> next cycle out_valid=0, 8'hFF never emerges, in_ready=1.
- REGISTER_PIPE_LEVEL_EN build: level steps 0,1,2,3 while filling with out_ready=0, full=1 at 3, level=0 after flush.
